cr_prefix_pf_pack: RTL and testbench

//  Prefix-output buffer and packer at the far end of the REC prefix interface.

---
 rtl/cr_prefix_pf_pack.sv | 138 +++++++++++++
 tb/tb_cr_prefix_pf_pack.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cr_prefix_pf_pack.sv
// Prefix-output buffer: an entry FIFO fed by the REC micro-sequencer, drained in order
// into little-endian 64-bit beats presented on a valid/ready output.
module cr_prefix_pf_pack #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 4,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_us_prefix_valid,
  input  logic [8:0]       rec_us_pf_datain,
  output logic             pf_full,
  output logic             pf_afull,
  output logic             pf_ob_valid,
  input  logic             pf_ob_ready,
  output logic [63:0]      pf_ob_data,
  output logic [3:0]       pf_ob_bytes,
  output logic             pf_ob_last,
  output logic             pf_overflow,
  output logic [CNT_W-1:0] pf_count
);

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [8:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [63:0]        lanes_q, lanes_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic               ob_valid_q, ob_valid_d;
  logic [63:0]        ob_data_q, ob_data_d;
  logic [3:0]         ob_bytes_q, ob_bytes_d;
  logic               ob_last_q, ob_last_d;
  logic               ovf_q;
  logic               push_s, pop_s;
  logic [8:0]         head_s;

  // Back-pressure looks only at the registered count; a same-cycle pop never frees a slot.
  assign pf_full  = (count_q == CNT_W'(DEPTH));
  assign pf_afull = (count_q >= CNT_W'(DEPTH - AFULL_LVL));
  assign push_s   = rec_us_prefix_valid && !pf_full;
  assign head_s   = mem_q[rd_ptr_q];

  assign pf_ob_valid = ob_valid_q;
  assign pf_ob_data  = ob_data_q;
  assign pf_ob_bytes = ob_bytes_q;
  assign pf_ob_last  = ob_last_q;
  assign pf_overflow = ovf_q;
  assign pf_count    = count_q;

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    byte_idx_d = byte_idx_q;
    ob_valid_d = ob_valid_q;
    ob_data_d  = ob_data_q;
    ob_bytes_d = ob_bytes_q;
    ob_last_d  = ob_last_q;
    pop_s      = 1'b0;
    case (state_q)
      FILL: begin
        if (count_q != '0) begin
          pop_s = 1'b1;
          lanes_d[{byte_idx_q, 3'b000} +: 8] = head_s[7:0];
          if (head_s[8] || (byte_idx_q == 3'd7)) begin
            ob_valid_d = 1'b1;
            ob_data_d  = lanes_d;
            ob_bytes_d = {1'b0, byte_idx_q} + 4'd1;
            ob_last_d  = head_s[8];
            state_d    = SEND;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end else begin
          state_d = FILL;
        end
      end
      SEND: begin
        if (pf_ob_ready) begin
          lanes_d    = 64'd0;
          byte_idx_d = 3'd0;
          ob_valid_d = 1'b0;
          ob_data_d  = 64'd0;
          ob_bytes_d = 4'd0;
          ob_last_d  = 1'b0;
          state_d    = FILL;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = FILL;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lanes_q    <= 64'd0;
      byte_idx_q <= 3'd0;
      ob_valid_q <= 1'b0;
      ob_data_q  <= 64'd0;
      ob_bytes_q <= 4'd0;
      ob_last_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_q   <= pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_q    <= count_d;
      lanes_q    <= lanes_d;
      byte_idx_q <= byte_idx_d;
      ob_valid_q <= ob_valid_d;
      ob_data_q  <= ob_data_d;
      ob_bytes_q <= ob_bytes_d;
      ob_last_q  <= ob_last_d;
      ovf_q      <= ovf_q | (rec_us_prefix_valid & pf_full);
    end
  end

  // Entry storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rec_us_pf_datain;
    end
  end

endmodule

// File: tb/tb_cr_prefix_pf_pack.sv
// Bench for cr_prefix_pf_pack: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model of the FIFO and beat packer.
module tb_cr_prefix_pf_pack;

  localparam int DEPTH = 16;
  localparam int AFULL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_us_prefix_valid;
  logic [8:0]  rec_us_pf_datain;
  logic        pf_full, pf_afull, pf_ob_valid, pf_ob_ready, pf_ob_last, pf_overflow;
  logic [63:0] pf_ob_data;
  logic [3:0]  pf_ob_bytes;
  logic [4:0]  pf_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [8:0]  m_q[$];
  logic [7:0]  m_p[$];
  bit          m_send;
  logic [63:0] m_data;
  int          m_bytes;
  bit          m_last;
  bit          m_ovf;

  // Beats observed being accepted by downstream
  logic [63:0] acc_data[$];
  int          acc_bytes[$];
  bit          acc_last[$];

  cr_prefix_pf_pack #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rec_us_prefix_valid (rec_us_prefix_valid),
    .rec_us_pf_datain    (rec_us_pf_datain),
    .pf_full             (pf_full),
    .pf_afull            (pf_afull),
    .pf_ob_valid         (pf_ob_valid),
    .pf_ob_ready         (pf_ob_ready),
    .pf_ob_data          (pf_ob_data),
    .pf_ob_bytes         (pf_ob_bytes),
    .pf_ob_last          (pf_ob_last),
    .pf_overflow         (pf_overflow),
    .pf_count            (pf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_p.delete();
    m_send  = 1'b0;
    m_data  = 64'd0;
    m_bytes = 0;
    m_last  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock of the reference: sending beat waits for ready; otherwise consume one entry.
  task automatic model_update(input logic v, input logic [8:0] d, input logic r);
    bit full;
    logic [8:0] e;
    full = (m_q.size() == DEPTH);
    if (v && full) m_ovf = 1'b1;
    if (m_send) begin
      if (r) m_send = 1'b0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_p.push_back(e[7:0]);
      if (e[8] || m_p.size() == 8) begin
        m_data = 64'd0;
        for (int i = 0; i < m_p.size(); i++) m_data = m_data | (64'(m_p[i]) << (8 * i));
        m_bytes = m_p.size();
        m_last  = e[8];
        m_send  = 1'b1;
        m_p.delete();
      end
    end
    if (v && !full) m_q.push_back(d);
  endtask

  task automatic compare_all();
    check("count", 64'(pf_count), 64'(m_q.size()));
    check("full",  64'(pf_full),  64'(m_q.size() == DEPTH));
    check("afull", 64'(pf_afull), 64'(m_q.size() >= DEPTH - AFULL));
    check("ovf",   64'(pf_overflow), 64'(m_ovf));
    check("valid", 64'(pf_ob_valid), 64'(m_send));
    if (m_send) begin
      check("data",  pf_ob_data, m_data);
      check("bytes", 64'(pf_ob_bytes), 64'(m_bytes));
      check("last",  64'(pf_ob_last), 64'(m_last));
    end
  endtask

  task automatic step(input logic v, input logic [8:0] d, input logic r);
    rec_us_prefix_valid = v;
    rec_us_pf_datain    = d;
    pf_ob_ready         = r;
    if (pf_ob_valid && r) begin
      acc_data.push_back(pf_ob_data);
      acc_bytes.push_back(int'(pf_ob_bytes));
      acc_last.push_back(pf_ob_last);
    end
    model_update(v, d, r);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rec_us_prefix_valid = 1'b0;
    rec_us_pf_datain    = 9'd0;
    pf_ob_ready         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("rst_valid", 64'(pf_ob_valid), 64'd0);
    check("rst_count", 64'(pf_count), 64'd0);
    check("rst_ovf",   64'(pf_overflow), 64'd0);
    check("rst_full",  64'(pf_full), 64'd0);
    check("rst_afull", 64'(pf_afull), 64'd0);
    check("rst_data",  pf_ob_data, 64'd0);
    check("rst_bytes", 64'(pf_ob_bytes), 64'd0);
    check("rst_last",  64'(pf_ob_last), 64'd0);
  endtask

  task automatic acc_clear();
    acc_data.delete();
    acc_bytes.delete();
    acc_last.delete();
  endtask

  initial begin
    rst = 1'b1;
    rec_us_prefix_valid = 1'b0;
    rec_us_pf_datain    = 9'd0;
    pf_ob_ready         = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single last-byte prefix: valid two edges after the push is sampled
    step(1'b1, 9'h1A5, 1'b0);
    step(1'b0, 9'h000, 1'b0);
    check("t1_valid", 64'(pf_ob_valid), 64'd1);
    check("t1_data",  pf_ob_data, 64'h00000000000000A5);
    check("t1_bytes", 64'(pf_ob_bytes), 64'd1);
    check("t1_last",  64'(pf_ob_last), 64'd1);
    step(1'b0, 9'h000, 1'b1);
    check("t1_drop",  64'(pf_ob_valid), 64'd0);

    // 11-byte prefix spans two beats
    acc_clear();
    for (int i = 1; i <= 11; i++) step(1'b1, {(i == 11), 8'(i)}, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 9'h000, 1'b1);
    check("t2_nbeats", 64'(acc_data.size()), 64'd2);
    if (acc_data.size() >= 2) begin
      check("t2_b0_data",  acc_data[0], 64'h0807060504030201);
      check("t2_b0_bytes", 64'(acc_bytes[0]), 64'd8);
      check("t2_b0_last",  64'(acc_last[0]), 64'd0);
      check("t2_b1_data",  acc_data[1], 64'h00000000000B0A09);
      check("t2_b1_bytes", 64'(acc_bytes[1]), 64'd3);
      check("t2_b1_last",  64'(acc_last[1]), 64'd1);
    end

    // Exactly 8 bytes: one beat, no empty trailer
    acc_clear();
    for (int i = 0; i < 8; i++) step(1'b1, {(i == 7), 8'(8'h10 + i)}, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 9'h000, 1'b1);
    check("t5_nbeats", 64'(acc_data.size()), 64'd1);
    if (acc_data.size() >= 1) begin
      check("t5_data",  acc_data[0], 64'h1716151413121110);
      check("t5_bytes", 64'(acc_bytes[0]), 64'd8);
      check("t5_last",  64'(acc_last[0]), 64'd1);
    end

    // Fill with ready low until full, then overflow
    for (int i = 0; i < 30; i++) step(1'b1, {1'b0, 8'($urandom)}, 1'b0);
    check("t3_count", 64'(pf_count), 64'd16);
    check("t3_full",  64'(pf_full), 64'd1);
    check("t3_ovf",   64'(pf_overflow), 64'd1);

    // Full: accept beat (no pop), then pop with push pending -> push still rejected
    step(1'b1, 9'h055, 1'b1);
    step(1'b1, 9'h066, 1'b0);
    check("t4_count", 64'(pf_count), 64'd15);
    check("t4_full",  64'(pf_full), 64'd0);

    // Drive back into SEND with entries queued, then reset
    for (int i = 0; i < 10; i++) step(1'b0, 9'h000, 1'b0);
    check("t6_pre_valid", 64'(pf_ob_valid), 64'd1);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 6), {($urandom_range(0, 4) == 0), 8'($urandom)},
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
